// File: rtl/stream_rr_arbiter.sv
// Burst-level round-robin arbiter feeding one registered valid/ready stream.
// A requester that wins keeps the grant until it sends `last` or MAX_BURST
// beats. The single output stage registers valid, data, last and source ID.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no burst open; next winner is the first valid at or after ptr
// LOCKED | burst open; only the owner (held in ptr) may transfer
module stream_rr_arbiter #(
    parameter int N         = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4,
    parameter int SW        = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    output logic [SW-1:0]      out_src,
    output logic               busy,
    output logic [SW-1:0]      owner
);

    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t        state;
    // In IDLE this is the round-robin search start; in LOCKED it is the
    // burst owner. The two are never needed at the same time, so one
    // register serves both and also drives the owner output directly.
    logic [SW-1:0] ptr;
    logic [CW-1:0] cnt;

    logic [SW-1:0] sel;
    logic          sel_ok;
    logic          ld;
    logic          xfer;
    logic          sel_last;
    logic [SW-1:0] sel_next;

    assign ld = !out_valid || out_ready;

    // Candidate: owner when locked, else first valid requester from ptr with wrap
    always_comb begin
        int idx;
        sel    = ptr;
        sel_ok = 1'b0;
        idx    = 0;
        if (state == LOCKED) begin
            sel_ok = 1'b1;
        end else begin
            // Scan from farthest to nearest so the nearest valid wins last.
            for (int k = N - 1; k >= 0; k--) begin
                idx = int'(ptr) + k;
                if (idx >= N) idx = idx - N;
                if (in_valid[idx]) begin
                    sel    = SW'(idx);
                    sel_ok = 1'b1;
                end
            end
        end
    end

    // Only the candidate sees ready, and never while reset is asserted
    always_comb begin
        in_ready      = '0;
        in_ready[sel] = ld && sel_ok && rst;
    end

    assign xfer     = in_valid[sel] && in_ready[sel];
    assign sel_last = in_last[sel] ||
                      ((state == IDLE) ? (MAX_BURST == 1)
                                       : (cnt == CW'(MAX_BURST - 1)));
    assign sel_next = (sel == SW'(N - 1)) ? '0 : sel + SW'(1);

    // Burst tracking: lock on a non-final beat, release and advance on the final one
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ptr   <= '0;
            cnt   <= '0;
        end else if (xfer) begin
            if (sel_last) begin
                state <= IDLE;
                ptr   <= sel_next;
                cnt   <= '0;
            end else begin
                state <= LOCKED;
                ptr   <= sel;
                cnt   <= cnt + CW'(1);
            end
        end
    end

    // Output stage: load on transfer, otherwise empty once drained
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data[sel*WIDTH +: WIDTH];
            out_last  <= in_last[sel];
            out_src   <= sel;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign busy  = (state == LOCKED);
    assign owner = ptr;

endmodule

// File: doc/stream_rr_arbiter.md
# stream_rr_arbiter

Round-robin arbiter that shares one downstream valid/ready stream, normally the input of a `pyc_fifo`, between `N` requesting streams. Arbitration is per burst: once a requester wins, it keeps the grant until it sends a beat with `last` set or reaches `MAX_BURST` beats. A one-deep registered output stage holds the winning beat, so the downstream FIFO sees registered valid, data and source ID.

## Interface
- `N`, default 4: number of requesters, ≥2.
- `WIDTH`, default 8: data width per beat.
- `MAX_BURST`, default 4: maximum beats per grant, ≥1. A value of 1 gives pure beat-level round robin.
- `SW`, default `$clog2(N)`: width of the source ID, derived.
- `clk`, in, 1: single clock. All state is on its rising edge.
- `rst`, in, 1: asynchronous, active-low reset. `rst`=0 resets immediately; release is synchronous to `clk`.
- `in_valid`, in, `N`: per-requester valid.
- `in_ready`, out, `N`: per-requester ready. At most one bit is high.
- `in_data`, in, `N*WIDTH`: flat bus. Requester i occupies `[i*WIDTH +: WIDTH]`.
- `in_last`, in, `N`: per-requester end-of-burst marker.
- `out_valid`, out, 1: output register holds a beat.
- `out_ready`, in, 1: downstream accept.
- `out_data`, out, `WIDTH`: registered beat data.
- `out_last`, out, 1: registered `last`.
- `out_src`, out, `SW`: index of the requester that supplied the beat.
- `busy`, out, 1: state is `LOCKED`.
- `owner`, out, `SW`: current owner in `LOCKED`. Equals `ptr` in `IDLE`.

## Operation
- Load enable is `ld = !out_valid || out_ready`. A beat transfers from requester g when `in_valid[g] && in_ready[g]`.
- State `IDLE`:
  - g is the first set `in_valid` bit, searching upward from `ptr` with wrap (`ptr`, `ptr+1`, …, `N-1`, `0`, …).
  - `in_ready[g] = ld`. All other `in_ready` bits are 0.
  - On transfer, if `in_last[g]` or `MAX_BURST==1`: stay in `IDLE` and set `ptr = (g+1) mod N`.
  - Otherwise go to `LOCKED` with `owner = g` and `cnt = 1`.
  - If no `in_valid` bit is set, nothing changes.
- State `LOCKED`:
  - Only the owner may transfer: `in_ready[owner] = ld`.
  - On transfer, if `in_last[owner]` or `cnt+1 == MAX_BURST`: go to `IDLE`, set `ptr = (owner+1) mod N` and `cnt = 0`.
  - Otherwise `cnt` increments.
  - If the owner drops `in_valid`, the arbiter stays `LOCKED` with no timeout. Other requesters are blocked.
- Output register:
  - On transfer, `out_data`, `out_last` and `out_src` load the winner's beat and `out_valid` goes to 1.
  - If `out_valid && out_ready` with no transfer, `out_valid` goes to 0 and the data registers hold.
  - Accepting a new beat in the same cycle as draining the old one replaces the register contents with no bubble.
- `cnt` width is `$clog2(MAX_BURST+1)`. `ptr` and `owner` wrap modulo N. The wrap must be correct when N is not a power of 2.
- `in_ready` is combinational from `in_valid`, `out_valid`, `out_ready` and state. There are no combinational paths from `in_data` or `in_last`.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_last`=0, `out_src`=0, `busy`=0, `owner`=0.
  - Internally: `ptr`=0, `cnt`=0, state `IDLE`.
  - `in_ready` = 0 while `rst`=0.
- Latency: a beat accepted at edge k is presented on the outputs after edge k.
- Throughput: one beat per cycle while `out_ready`=1.
- When `out_ready` is low with `out_valid`=1, all `in_ready` bits are 0 and the outputs hold stable.
- Reset asserted mid-burst:
  - All state clears at once and the in-flight output beat is discarded.
  - After release, arbitration restarts from requester 0.

## Test plan
- **Round robin.** N=4, MAX_BURST=1, all `in_valid`=1, `out_ready`=1, data = 0x10+i → `out_src` sequence 0,1,2,3,0. One beat per cycle. First `out_valid` appears the cycle after reset release.
- **Burst lock.** MAX_BURST=4, requesters 1 and 2 valid, requester 1 never asserts `last` → four beats with `out_src`=1, then requester 2. `busy` is high for cycles 1–3 of the burst.
- **Early last.** Requester 0 sends 2 beats with `last` on beat 2 while requester 3 is valid → grant moves to 3 after beat 2. `out_last`=1 on the second output beat.
- **Backpressure.** `out_ready`=0 for 5 cycles with `out_valid`=1 → all `in_ready` are 0 and `out_data` is stable. When `out_ready` returns to 1, transfers resume with no lost or duplicated beat (scoreboard per source).
- **Stalled owner and wrap.** N=3: the owner drops `in_valid` mid-burst → no other grants until it resumes. A grant starting at `ptr`=2 must wrap to requester 0 next.
- **Async reset.** Pull `rst` low mid-burst, between clock edges → `out_valid` is 0 immediately. After release, the first grant goes to the lowest-index valid requester.
